// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op codes, state encodings and op-class helpers for the load/store unit
//
// Purpose : common types for lsu_dm_master and lsu_extend.
// Contents: lsu_op_e (request op codes), lsu_state_e (FSM states),
//           is_store / is_half / is_byte op-class helpers.
package lsu_pkg;

   typedef enum logic [2:0] {
      LW  = 3'd0,
      LH  = 3'd1,
      LHU = 3'd2,
      LB  = 3'd3,
      LBU = 3'd4,
      SW  = 3'd5,
      SH  = 3'd6,
      SB  = 3'd7
   } lsu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   function automatic logic is_store(input lsu_op_e op);
      return (op == SW) || (op == SH) || (op == SB);
   endfunction

   function automatic logic is_half(input lsu_op_e op);
      return (op == LH) || (op == LHU) || (op == SH);
   endfunction

   function automatic logic is_byte(input lsu_op_e op);
      return (op == LB) || (op == LBU) || (op == SB);
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - combinational load-data extension
//
// Purpose: forms the 32-bit load result from the op code and memory data.
// Ports  : op_i    - latched request op code
//          lo_i    - low byte of a halfword load
//          hi_i    - high byte of a halfword load
//          dout_i  - memory read data (byte mode already sign-extended)
//          rdata_o - extended load result, 0 for stores
module lsu_extend
   import lsu_pkg::*;
(
   input  lsu_op_e     op_i,
   input  logic [7:0]  lo_i,
   input  logic [7:0]  hi_i,
   input  logic [31:0] dout_i,
   output logic [31:0] rdata_o
);

   always_comb begin
      rdata_o = 32'd0;
      case (op_i)
         LW, LB: rdata_o = dout_i;
         LBU:    rdata_o = {24'd0, dout_i[7:0]};
         LH:     rdata_o = {{16{hi_i[7]}}, hi_i, lo_i};
         LHU:    rdata_o = {16'd0, hi_i, lo_i};
         default: rdata_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/lsu_dm_master.sv
// rtl/lsu_dm_master.sv - load/store unit driving the word/byte data memory port
//
// Purpose: accepts byte-addressed load/store requests, performs them on the
//          data memory (halfwords as two byte accesses) and returns extended
//          load data or an error flag.
// Ports  : clk, rst                      - clock, async active-high reset
//          req_valid/ready/op/addr/wdata - request handshake and payload
//          rsp_valid/ready/rdata/err     - response handshake and payload
//          dm_addr/din/we/bmode/bsel     - memory word address, data, controls
//          dm_dout                       - memory read data (combinational)
module lsu_dm_master
   import lsu_pkg::*;
#(
   parameter int ADDR_HI = 11
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_op,
   input  logic [31:0]        req_addr,
   input  logic [31:0]        req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_rdata,
   output logic               rsp_err,
   output logic [ADDR_HI-2:0] dm_addr,
   output logic [31:0]        dm_din,
   output logic               dm_we,
   output logic               dm_bmode,
   output logic [1:0]         dm_bsel,
   input  logic [31:0]        dm_dout
);

   lsu_state_e        state_q, state_d;
   lsu_op_e           op_q;
   logic [1:0]        lane_q;
   logic [31:0]       wdata_q;
   logic [7:0]        lo_q;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;
   logic [ADDR_HI-2:0] dm_addr_q;

   lsu_op_e           req_op_e;
   logic              req_err;
   logic [7:0]        ext_lo;
   logic [31:0]       ext_rdata;

   assign req_op_e = lsu_op_e'(req_op);

   // Rejected requests: misaligned word/halfword, or any address bit above
   // the memory's decoded range.
   always_comb begin
      req_err = (req_addr >> (ADDR_HI + 1)) != 32'd0;
      if (is_half(req_op_e) && req_addr[0])
         req_err = 1'b1;
      if (!is_half(req_op_e) && !is_byte(req_op_e) && (req_addr[1:0] != 2'b00))
         req_err = 1'b1;
   end

   // In ACC1 the low byte comes from the ACC0 capture; otherwise straight
   // from the memory.
   assign ext_lo = (state_q == ACC1) ? lo_q : dm_dout[7:0];

   lsu_extend u_extend (
      .op_i    (op_q),
      .lo_i    (ext_lo),
      .hi_i    (dm_dout[7:0]),
      .dout_i  (dm_dout),
      .rdata_o (ext_rdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_valid) state_d = req_err ? RESP : ACC0;
         ACC0: state_d = is_half(op_q) ? ACC1 : RESP;
         ACC1: state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= LW;
         lane_q      <= 2'd0;
         wdata_q     <= 32'd0;
         lo_q        <= 8'd0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         dm_addr_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op_e;
                  lane_q  <= req_addr[1:0];
                  wdata_q <= req_wdata;
                  if (req_err) begin
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'd0;
                  end else begin
                     rsp_err_q <= 1'b0;
                     // Only real accesses move the memory address.
                     dm_addr_q <= req_addr[ADDR_HI:2];
                  end
               end
            end
            ACC0: begin
               if (is_half(op_q))
                  lo_q <= dm_dout[7:0];
               else
                  rsp_rdata_q <= is_store(op_q) ? 32'd0 : ext_rdata;
            end
            ACC1: begin
               rsp_rdata_q <= is_store(op_q) ? 32'd0 : ext_rdata;
            end
            default: ;
         endcase
      end
   end

   // Memory controls decode from state so they collapse the moment rst
   // clears the state register.
   always_comb begin
      dm_we    = 1'b0;
      dm_bmode = 1'b0;
      dm_bsel  = 2'd0;
      dm_din   = 32'd0;
      case (state_q)
         ACC0: begin
            dm_we = is_store(op_q);
            if (is_half(op_q)) begin
               dm_bmode = 1'b1;
               dm_bsel  = {lane_q[1], 1'b0};
               if (is_store(op_q)) dm_din = {24'd0, wdata_q[7:0]};
            end else if (is_byte(op_q)) begin
               dm_bmode = 1'b1;
               dm_bsel  = lane_q;
               if (is_store(op_q)) dm_din = {24'd0, wdata_q[7:0]};
            end else begin
               if (is_store(op_q)) dm_din = wdata_q;
            end
         end
         ACC1: begin
            dm_we    = is_store(op_q);
            dm_bmode = 1'b1;
            dm_bsel  = {lane_q[1], 1'b1};
            if (is_store(op_q)) dm_din = {24'd0, wdata_q[15:8]};
         end
         default: ;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign dm_addr   = dm_addr_q;

endmodule

// File: tb/tb_lsu_dm_master.sv
// tb/tb_lsu_dm_master.sv - directed self-checking bench for lsu_dm_master
module tb_lsu_dm_master;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [9:0]  dm_addr;
   logic [31:0] dm_din;
   logic        dm_we;
   logic        dm_bmode;
   logic [1:0]  dm_bsel;
   logic [31:0] dm_dout;

   int errors = 0;
   int checks = 0;

   bit [31:0]   mem [1024];
   int          we_cnt = 0;
   int          act_cnt = 0;
   logic [1:0]  log_bsel  [16];
   logic        log_bmode [16];
   logic [7:0]  log_din   [16];

   always #5 clk = ~clk;

   lsu_dm_master dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .dm_addr   (dm_addr),
      .dm_din    (dm_din),
      .dm_we     (dm_we),
      .dm_bmode  (dm_bmode),
      .dm_bsel   (dm_bsel),
      .dm_dout   (dm_dout)
   );

   // Memory model: combinational read, byte mode returns the lane sign-extended.
   logic [31:0] cur_word;
   logic [7:0]  cur_byte;
   always_comb begin
      cur_word = mem[dm_addr];
      cur_byte = cur_word[8*dm_bsel +: 8];
      dm_dout  = dm_bmode ? {{24{cur_byte[7]}}, cur_byte} : cur_word;
   end

   always @(posedge clk) begin
      if (dm_we) begin
         log_bsel[we_cnt % 16]  = dm_bsel;
         log_bmode[we_cnt % 16] = dm_bmode;
         log_din[we_cnt % 16]   = dm_din[7:0];
         if (dm_bmode) mem[dm_addr][8*dm_bsel +: 8] <= dm_din[7:0];
         else          mem[dm_addr] <= dm_din;
         we_cnt = we_cnt + 1;
      end
      if (dm_we || dm_bmode) act_cnt = act_cnt + 1;
   end

   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err);
      req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if ({rsp_valid, rsp_err, dm_we, dm_bmode} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {rsp_valid, rsp_err, dm_we, dm_bmode}); end
      checks++; if ({rsp_rdata, dm_din, dm_addr, dm_bsel} !== 76'd0) begin errors++; $display("FAIL reset_data rdata=%h din=%h addr=%h bsel=%h exp=0", rsp_rdata, dm_din, dm_addr, dm_bsel); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      int lat; logic [31:0] rd; logic er; int base;
      base = we_cnt;
      do_req(SW, 32'h010, 32'hDEADBEEF, lat, rd, er);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
      checks++; if ({er, rd} !== 33'd0) begin errors++; $display("FAIL sw_rsp err=%b rdata=%h exp=0/0", er, rd); end
      checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL sw_we_pulses got=%0d exp=1", we_cnt - base); end
      checks++; if (log_bmode[base % 16] !== 1'b0) begin errors++; $display("FAIL sw_bmode got=%b exp=0", log_bmode[base % 16]); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
      checks++; if (dm_addr !== 10'h004) begin errors++; $display("FAIL sw_dm_addr got=%h exp=004", dm_addr); end
      do_req(LW, 32'h010, 32'd0, lat, rd, er);
      checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
      checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL lw_rsp err=%b rdata=%h exp=0/deadbeef", er, rd); end
      checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL lw_no_write got=%0d exp=1", we_cnt - base); end
   endtask

   task automatic test_byte();
      int lat; logic [31:0] rd; logic er; int base;
      base = we_cnt;
      do_req(SB, 32'h013, 32'h000000F0, lat, rd, er);
      checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL sb_we_pulses got=%0d exp=1", we_cnt - base); end
      checks++; if ({log_bmode[base % 16], log_bsel[base % 16], log_din[base % 16]} !== {1'b1, 2'd3, 8'hF0})
         begin errors++; $display("FAIL sb_lines bmode=%b bsel=%0d din=%h exp=1/3/f0", log_bmode[base % 16], log_bsel[base % 16], log_din[base % 16]); end
      checks++; if (mem[4] !== 32'hF0ADBEEF) begin errors++; $display("FAIL sb_mem got=%h exp=f0adbeef", mem[4]); end
      do_req(LB, 32'h013, 32'd0, lat, rd, er);
      checks++; if ({er, rd} !== {1'b0, 32'hFFFFFFF0} || lat !== 2) begin errors++; $display("FAIL lb_rsp err=%b rdata=%h lat=%0d exp=0/fffffff0/2", er, rd, lat); end
      do_req(LBU, 32'h013, 32'd0, lat, rd, er);
      checks++; if ({er, rd} !== {1'b0, 32'h000000F0} || lat !== 2) begin errors++; $display("FAIL lbu_rsp err=%b rdata=%h lat=%0d exp=0/000000f0/2", er, rd, lat); end
   endtask

   task automatic test_half();
      int lat; logic [31:0] rd; logic er; int base;
      base = we_cnt;
      do_req(SH, 32'h022, 32'h00008001, lat, rd, er);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency got=%0d exp=3", lat); end
      checks++; if (we_cnt - base !== 2) begin errors++; $display("FAIL sh_we_pulses got=%0d exp=2", we_cnt - base); end
      checks++; if ({log_bsel[base % 16], log_din[base % 16]} !== {2'd2, 8'h01}) begin errors++; $display("FAIL sh_first bsel=%0d din=%h exp=2/01", log_bsel[base % 16], log_din[base % 16]); end
      checks++; if ({log_bsel[(base + 1) % 16], log_din[(base + 1) % 16]} !== {2'd3, 8'h80}) begin errors++; $display("FAIL sh_second bsel=%0d din=%h exp=3/80", log_bsel[(base + 1) % 16], log_din[(base + 1) % 16]); end
      checks++; if (mem[8] !== 32'h80010000) begin errors++; $display("FAIL sh_mem got=%h exp=80010000", mem[8]); end
      do_req(LH, 32'h022, 32'd0, lat, rd, er);
      checks++; if ({er, rd} !== {1'b0, 32'hFFFF8001} || lat !== 3) begin errors++; $display("FAIL lh_rsp err=%b rdata=%h lat=%0d exp=0/ffff8001/3", er, rd, lat); end
      do_req(LHU, 32'h022, 32'd0, lat, rd, er);
      checks++; if ({er, rd} !== {1'b0, 32'h00008001} || lat !== 3) begin errors++; $display("FAIL lhu_rsp err=%b rdata=%h lat=%0d exp=0/00008001/3", er, rd, lat); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic er; int base;
      logic [2:0]  ops   [3];
      logic [31:0] addrs [3];
      ops[0] = LW; addrs[0] = 32'h011;
      ops[1] = SH; addrs[1] = 32'h021;
      ops[2] = SW; addrs[2] = 32'h1000;
      base = we_cnt;
      for (int i = 0; i < 3; i++) begin
         do_req(ops[i], addrs[i], 32'hFFFFFFFF, lat, rd, er);
         checks++; if ({lat[3:0], er, rd} !== {4'd1, 1'b1, 32'd0}) begin errors++; $display("FAIL err_case%0d lat=%0d err=%b rdata=%h exp=1/1/0", i, lat, er, rd); end
      end
      checks++; if (we_cnt - base !== 0) begin errors++; $display("FAIL err_no_write got=%0d exp=0", we_cnt - base); end
      checks++; if ({mem[0], mem[8]} !== {32'd0, 32'h80010000}) begin errors++; $display("FAIL err_mem mem0=%h mem8=%h exp=0/80010000", mem[0], mem[8]); end
   endtask

   task automatic test_stall();
      int cyc; int base_act;
      req_op = LW; req_addr = 32'h010; req_wdata = 32'd0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_op = LBU; req_addr = 32'h013;
      cyc = 1;
      while (!rsp_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
      checks++; if (cyc !== 2) begin errors++; $display("FAIL stall_latency got=%0d exp=2", cyc); end
      base_act = act_cnt;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hF0ADBEEF}) begin
            errors++; $display("FAIL stall_hold%0d valid=%b ready=%b err=%b rdata=%h exp=1/0/0/f0adbeef", i, rsp_valid, req_ready, rsp_err, rsp_rdata);
         end
         @(posedge clk); #1;
      end
      checks++; if (act_cnt - base_act !== 0) begin errors++; $display("FAIL stall_dm_activity got=%0d exp=0", act_cnt - base_act); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL stall_release ready=%b valid=%b exp=1/0", req_ready, rsp_valid); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if ({req_ready, dm_bmode, dm_bsel} !== {1'b0, 1'b1, 2'd3}) begin errors++; $display("FAIL next_accept ready=%b bmode=%b bsel=%0d exp=0/1/3", req_ready, dm_bmode, dm_bsel); end
      cyc = 0;
      while (!rsp_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
      checks++; if (rsp_rdata !== 32'h000000F0) begin errors++; $display("FAIL next_rdata got=%h exp=000000f0", rsp_rdata); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic er; int base;
      base = we_cnt;
      req_op = SH; req_addr = 32'h030; req_wdata = 32'h0000A55A; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if ({dm_we, dm_bmode, dm_bsel, dm_din[7:0]} !== {1'b1, 1'b1, 2'd1, 8'hA5}) begin errors++; $display("FAIL acc1_lines we=%b bmode=%b bsel=%0d din=%h exp=1/1/1/a5", dm_we, dm_bmode, dm_bsel, dm_din[7:0]); end
      rst = 1'b1;
      #1;
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rst_we_drop got=%b exp=0", dm_we); end
      checks++; if ({req_ready, rsp_valid, rsp_err, dm_bmode, dm_bsel} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin errors++; $display("FAIL rst_ctrl ready=%b valid=%b err=%b bmode=%b bsel=%0d exp=1/0/0/0/0", req_ready, rsp_valid, rsp_err, dm_bmode, dm_bsel); end
      checks++; if ({rsp_rdata, dm_din, dm_addr} !== 74'd0) begin errors++; $display("FAIL rst_data rdata=%h din=%h addr=%h exp=0", rsp_rdata, dm_din, dm_addr); end
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL rst_we_pulses got=%0d exp=1", we_cnt - base); end
      checks++; if (mem[12] !== 32'h0000005A) begin errors++; $display("FAIL rst_partial_mem got=%h exp=0000005a", mem[12]); end
      @(posedge clk); #1;
      do_req(LHU, 32'h030, 32'd0, lat, rd, er);
      checks++; if ({er, rd} !== {1'b0, 32'h0000005A} || lat !== 3) begin errors++; $display("FAIL post_rst_lhu err=%b rdata=%h lat=%0d exp=0/0000005a/3", er, rd, lat); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_dm_master.md
Name: lsu_dm_master

Overview:
Load/store unit that sits between the CPU datapath and the 4 KiB data memory; it is the initiator side of the memory's word/byte interface.
- Accepts byte-addressed load/store requests through a valid/ready handshake.
- Drives the memory's word address, write data, write enable, byte-mode and byte-select lines.
- Builds halfword accesses from two sequential byte accesses.
- Returns zero- or sign-extended load data and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_HI, 11, highest address bit decoded by the memory; any set bit above ADDR_HI is out of range.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  operation code (see Decomposition)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores
- rsp_err  out  1  access rejected (misaligned or out of range)
- dm_addr  out  10  word address, = req_addr[ADDR_HI:2]
- dm_din  out  32  memory write data; byte mode uses bits [7:0]
- dm_we  out  1  memory write enable
- dm_bmode  out  1  1 = byte access, 0 = word access
- dm_bsel  out  2  byte lane within the word
- dm_dout  in  32  memory read data
  - combinational from the memory
  - in byte mode the memory returns the selected byte sign-extended

Behaviour:
Clocking and reset:
- Single clock domain, clk.
- rst is asynchronous and active-high; it forces state IDLE and clears all registers.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_we=0, dm_bmode=0, dm_bsel=0, dm_addr=0, dm_din=0.
- dm_we is decoded from state, so it drops immediately on rst, even mid-access.

States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/addr/wdata.
  - If error, go to RESP with rsp_err=1 and no memory access.
  - Otherwise go to ACC0.
- ACC0:
  - Drive the dm lines from the latched request.
  - Word op (LW/SW): bmode=0.
  - Byte op: bmode=1, bsel=addr[1:0].
  - Halfword op: bmode=1, bsel={addr[1],0}.
  - Stores assert dm_we=1; the write commits on the ACC0 to next-state edge. The byte store value is wdata[7:0].
  - Loads capture dm_dout at the end of ACC0.
  - Next state is ACC1 for halfword ops, RESP otherwise.
- ACC1 (halfword ops only):
  - bmode=1, bsel={addr[1],1}.
  - SH writes wdata[15:8].
  - LH/LHU capture dm_dout[7:0] as the high byte.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready go to IDLE.
  - No new request is accepted in RESP (req_ready=0); there is no back-to-back overlap.

Outside ACC0/ACC1, dm_we=0, dm_bmode=0, dm_bsel=0 and dm_addr holds its last value.

Extension rules:
- LW: rdata = dm_dout.
- LB: rdata = dm_dout, already sign-extended by the memory.
- LBU: rdata = {24'b0, dm_dout[7:0]}.
- LH: {{16{hi[7]}}, hi, lo}.
- LHU: {16'b0, hi, lo}.

Errors (rdata=0, no dm_we):
- Word op with addr[1:0]≠0.
- Halfword op with addr[0]=1.
- Any op with addr[31:ADDR_HI+1]≠0.

Latency and boundaries:
- Latency from accept edge to rsp_valid: 2 cycles for word/byte ops, 3 for halfword ops, 1 for errors.
- rsp_ready held low: the response persists indefinitely and the memory is not touched again.
- req_valid asserted during RESP: ignored until IDLE.
- Reset between the two SH writes leaves the low byte written and the high byte unwritten. This is accepted.

Decomposition:
- Shared package lsu_pkg holds:
  - op codes: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7
  - state encodings: IDLE=0, ACC0=1, ACC1=2, RESP=3
  - helper functions is_store, is_half, is_byte
- One natural sub-module, lsu_extend: combinational load-data extension from op, lo and hi bytes, and dm_dout.

Test Plan:
1. SW addr 0x010 wdata 0xDEADBEEF, then LW 0x010 -> dm_addr=0x004, one dm_we pulse with bmode=0; rsp_rdata=0xDEADBEEF after 2 cycles, rsp_err=0.
2. SB 0x013 wdata 0x000000F0, then LB 0x013 and LBU 0x013 -> bsel=3 on write; LB returns 0xFFFFFFF0, LBU returns 0x000000F0.
3. SH 0x022 wdata 0x00008001 -> two dm_we cycles: bsel=2 with din[7:0]=0x01, then bsel=3 with 0x80. LH 0x022 returns 0xFFFF8001; LHU returns 0x00008001; latency is 3 cycles.
4. LW 0x011, SH 0x021 and SW 0x1000 -> rsp_err=1 after 1 cycle, rsp_rdata=0, dm_we never asserted.
5. LW response with rsp_ready held low for 5 cycles while req_valid=1 -> rsp_valid and rdata stable, req_ready=0, no dm activity; accept the next request on the cycle after rsp_ready.
6. Assert rst during ACC1 of SH 0x030 -> dm_we falls immediately, state IDLE, all outputs at reset values, low byte at 0x030 written and high byte unchanged.
